// File: rtl/cmd_processor.sv
// Byte-stream command processor: parses header + argument bytes and executes
// CPU (NOOP/ADD/SUB) and memory (MWAIT/LOAD/STORE/COPY) commands.
module cmd_processor #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       cmd_done,
  output logic       err,
  input  logic [3:0] dbg_reg_sel,
  output logic [7:0] dbg_reg_data
);
  localparam int unsigned MemDepth = 1 << MEM_AW;

  localparam logic [7:0] OpNoop  = 8'h00;
  localparam logic [7:0] OpAdd   = 8'h01;
  localparam logic [7:0] OpSub   = 8'h02;
  localparam logic [7:0] OpMwait = 8'h40;
  localparam logic [7:0] OpLoad  = 8'h41;
  localparam logic [7:0] OpStore = 8'h42;
  localparam logic [7:0] OpCopy  = 8'h43;

  typedef enum logic {StHdr, StArg} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  arg_q [3];
  logic [7:0]  arg_d [3];
  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic [7:0]  mem [MemDepth];
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic        res_carry_q, res_carry_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        accept;
  logic [1:0]  arg_idx;
  logic [15:0] addr_ls, addr_src, addr_dst;
  logic [8:0]  sum, diff;
  logic        unused_addr_bits;

  function automatic logic [2:0] nargs_of(input logic [7:0] op);
    case (op)
      OpAdd, OpSub:    return 3'd2;
      OpLoad, OpStore: return 3'd3;
      OpCopy:          return 3'd4;
      default:         return 3'd0;
    endcase
  endfunction

  function automatic logic legal_hdr(input logic [7:0] op);
    case (op)
      OpNoop, OpAdd, OpSub, OpMwait, OpLoad, OpStore, OpCopy: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  assign in_ready = rst_n;
  assign accept   = in_valid && in_ready;

  // The final argument byte is used straight from in_data; earlier ones come from arg_q.
  assign addr_ls  = {arg_q[1], in_data};
  assign addr_src = {arg_q[0], arg_q[1]};
  assign addr_dst = {arg_q[2], in_data};
  assign sum      = {1'b0, arg_q[0]} + {1'b0, in_data};
  assign diff     = {1'b0, arg_q[0]} - {1'b0, in_data};
  assign arg_idx  = cnt_q[1:0] - 2'd1;

  assign unused_addr_bits = ^{addr_ls[15:MEM_AW], addr_src[15:MEM_AW], addr_dst[15:MEM_AW]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    arg_d       = arg_q;
    regs_d      = regs_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    if (accept) begin
      unique case (state_q)
        StHdr: begin
          if (!legal_hdr(in_data)) begin
            err_d = 1'b1;
          end else if (nargs_of(in_data) == 3'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StArg;
            op_d    = in_data;
            cnt_d   = 3'd1;
          end
        end
        StArg: begin
          if (cnt_q == nargs_of(op_q)) begin
            state_d = StHdr;
            done_d  = 1'b1;
            case (op_q)
              OpAdd: begin
                res_valid_d = 1'b1;
                res_data_d  = sum[7:0];
                res_carry_d = sum[8];
              end
              OpSub: begin
                res_valid_d = 1'b1;
                res_data_d  = diff[7:0];
                res_carry_d = diff[8];
              end
              OpLoad: regs_d[arg_q[0][3:0]] = mem[addr_ls[MEM_AW-1:0]];
              OpStore: begin
                mem_we    = 1'b1;
                mem_waddr = addr_ls[MEM_AW-1:0];
                mem_wdata = regs_q[arg_q[0][3:0]];
              end
              OpCopy: begin
                mem_we    = 1'b1;
                mem_waddr = addr_dst[MEM_AW-1:0];
                mem_wdata = mem[addr_src[MEM_AW-1:0]];
              end
              default: ;
            endcase
          end else begin
            arg_d[arg_idx] = in_data;
            cnt_d          = cnt_q + 3'd1;
          end
        end
        default: state_d = StHdr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHdr;
      op_q        <= '0;
      cnt_q       <= '0;
      arg_q       <= '{default: '0};
      regs_q      <= '{default: '0};
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      arg_q       <= arg_d;
      regs_q      <= regs_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_carry    = res_carry_q;
  assign cmd_done     = done_q;
  assign err          = err_q;
  assign dbg_reg_data = regs_q[dbg_reg_sel];

endmodule

// File: tb/tb_cmd_processor.sv
// Directed bench for cmd_processor: a reference model predicts pulses into a
// scoreboard queue and register contents for debug-port reads.
module tb_cmd_processor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       cmd_done;
  logic       err;
  logic [3:0] dbg_reg_sel = 4'h0;
  logic [7:0] dbg_reg_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       rv;
    logic       dn;
    logic       er;
    logic [7:0] data;
    logic       carry;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_regs [16];
  logic [7:0] model_mem [256];
  logic [7:0] last_res;

  cmd_processor #(.MEM_AW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .cmd_done     (cmd_done),
    .err          (err),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every output pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && (res_valid || cmd_done || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 16'({res_valid, cmd_done, err}), 16'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_flags", 16'({res_valid, cmd_done, err}), 16'({mon_e.rv, mon_e.dn, mon_e.er}));
        if (mon_e.rv) chk("result", 16'({res_carry, res_data}), 16'({mon_e.carry, mon_e.data}));
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap = 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic push(input logic rv, input logic dn, input logic er,
                      input logic [7:0] data, input logic carry);
    exp_q.push_back('{rv: rv, dn: dn, er: er, data: data, carry: carry});
  endtask

  task automatic cmd_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    send(8'h01); send(a); send(b);
    push(1'b1, 1'b1, 1'b0, s[7:0], s[8]);
    last_res = s[7:0];
  endtask

  task automatic cmd_sub(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    send(8'h02); send(a); send(b);
    push(1'b1, 1'b1, 1'b0, d, a < b);
    last_res = d;
  endtask

  task automatic cmd_load(input logic [3:0] r, input logic [15:0] addr, input int gap = 0);
    send(8'h41, gap); send({4'hF, r}, gap); send(addr[15:8], gap); send(addr[7:0]);
    push(1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
    model_regs[r] = model_mem[addr[7:0]];
  endtask

  task automatic cmd_store(input logic [3:0] r, input logic [15:0] addr);
    send(8'h42); send({4'h0, r}); send(addr[15:8]); send(addr[7:0]);
    push(1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
    model_mem[addr[7:0]] = model_regs[r];
  endtask

  task automatic cmd_copy(input logic [15:0] src, input logic [15:0] dst);
    send(8'h43); send(src[15:8]); send(src[7:0]); send(dst[15:8]); send(dst[7:0]);
    push(1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
    model_mem[dst[7:0]] = model_mem[src[7:0]];
  endtask

  task automatic cmd_single(input logic [7:0] h, input logic legal);
    send(h);
    push(1'b0, legal, !legal, 8'h0, 1'b0);
  endtask

  task automatic check_reg(input logic [3:0] r);
    @(negedge clk);
    in_valid    = 1'b0;
    dbg_reg_sel = r;
    #1;
    chk($sformatf("reg%0d", r), 16'(dbg_reg_data), 16'(model_regs[r]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    // Memory is not reset, so seed it through the hierarchy with a known pattern.
    for (int i = 0; i < 256; i++) begin
      dut.mem[i]   = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    last_res = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_pulses", 16'({res_valid, cmd_done, err}), 16'h0);
    chk("rst_res", 16'({res_carry, res_data}), 16'h0);
    rst_n = 1'b1;
    #1;
    chk("in_ready", 16'(in_ready), 16'h1);
    for (int r = 0; r < 16; r++) check_reg(4'(r));

    // Arithmetic, including carry/borrow edges.
    cmd_add(8'hF0, 8'h20);
    cmd_sub(8'h05, 8'h07);
    cmd_sub(8'h07, 8'h05);
    cmd_add(8'hFF, 8'h01);
    cmd_add(8'h7F, 8'h00);
    cmd_sub(8'h00, 8'h00);
    cmd_single(8'h00, 1'b1);
    idle(2);
    chk("res_hold", 16'(res_data), 16'(last_res));

    // Streamed back-to-back memory round trip.
    cmd_add(8'h11, 8'h22);
    cmd_load(4'd2, 16'h0010);
    cmd_copy(16'h0010, 16'h0020);
    cmd_load(4'd5, 16'h0020);
    check_reg(4'd5);
    check_reg(4'd2);
    cmd_load(4'd3, 16'h0077);
    cmd_store(4'd3, 16'h0050);
    cmd_load(4'd4, 16'h0050);
    check_reg(4'd4);

    // Address aliasing and self-copy.
    cmd_store(4'd4, 16'h1234);
    cmd_load(4'd6, 16'h0034);
    check_reg(4'd6);
    cmd_copy(16'hAB34, 16'h0034);
    cmd_load(4'd8, 16'h0034);
    check_reg(4'd8);

    // Illegal headers are single bytes; parsing restarts right after.
    cmd_single(8'h80, 1'b0);
    cmd_single(8'h00, 1'b1);
    cmd_single(8'hC1, 1'b0);
    cmd_single(8'h05, 1'b0);
    cmd_single(8'h44, 1'b0);
    cmd_single(8'h40, 1'b1);
    cmd_add(8'h80, 8'h80);

    // Gaps between bytes must not matter.
    cmd_load(4'd9, 16'h00C3, 2);
    check_reg(4'd9);
    idle(2);

    // Reset mid-command discards the partial LOAD.
    send(8'h41, 1);
    send(8'h0A, 1);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h00;
    #1;
    chk("rst_mid_in_ready", 16'(in_ready), 16'h0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    cmd_single(8'h40, 1'b1);
    for (int r = 0; r < 16; r++) check_reg(4'(r));
    chk("rst_res_clear", 16'({res_carry, res_data}), 16'h0);

    idle(4);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
